// File: rtl/key_sched_pkg.sv
// Shared types and constants for the key frame scheduler.
// Build option: define KEY_FRAME_CHECKSUM_EN to append an XOR checksum byte to every frame.
package key_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        SEND,
        WAIT,
        CSUM,
        DONE
    } state_t;

    // Header byte is HDR_BASE | source index.
    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

    // Source indices: four chaos-generator keys plus the x/y/z seed dump.
    localparam int KEY1 = 0;
    localparam int KEY2 = 1;
    localparam int KEY3 = 2;
    localparam int KEY4 = 3;
    localparam int SEED = 4;

endpackage

// File: rtl/key_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping around to index 0. Produces a one-hot grant and the binary index.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [N-1:0] mask;
    logic [N-1:0] hit;
    logic [N-1:0] pool;

    // Prefer requesters at or above ptr; fall back to the lowest requester overall.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a path that skips an assignment infers a latch.
        mask  = '0;
        hit   = '0;
        pool  = '0;
        grant = '0;
        idx   = '0;
        valid = |req;
        for (int i = 0; i < N; i++) begin
            mask[i] = (IW'(i) >= ptr);
        end
        hit  = req & mask;
        pool = (|hit) ? hit : req;
        // Walk downwards so the lowest set bit of the pool wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (pool[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/key_frame_scheduler.sv
// Key frame scheduler: shares one UART transmitter between N_SRC frame sources.
// Grants a source round-robin, snapshots its payload, then sends a header byte and the
// payload bytes one at a time over the tx_start/tx_ready/tx_done handshake.
// Build option: KEY_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte (header ^ payload).
module key_frame_scheduler
    import key_sched_pkg::*;
#(
    parameter int         N_SRC       = 5,
    parameter int         FRAME_BYTES = 48,
    parameter logic [7:0] HDR_BASE    = HDR_BASE_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [N_SRC-1:0]               req,
    input  logic [N_SRC*FRAME_BYTES*8-1:0] src_data,
    input  logic                           tx_ready,
    input  logic                           tx_done,
    output logic                           tx_start,
    output logic [7:0]                     tx_data,
    output logic [N_SRC-1:0]               grant,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int IW      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int FRAME_W = FRAME_BYTES * 8;
    localparam logic [CW-1:0] LAST_BYTE = CW'(FRAME_BYTES - 1);
`ifdef KEY_FRAME_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = CSUM;
`else
    localparam state_t AFTER_PAYLOAD = DONE;
`endif

    state_t               state;
    state_t               state_n;
    state_t               last_kind;   // which state issued the byte now in flight
    logic                 issue;       // a byte is handed to the transmitter this cycle
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        gidx;
    logic [IW-1:0]        arb_idx;
    logic [N_SRC-1:0]     arb_grant;
    logic                 arb_valid;
    logic [FRAME_W-1:0]   frame_buf;
    logic [FRAME_W-1:0]   sel_payload;
    logic [CW-1:0]        byte_cnt;
    logic [7:0]           cur_byte;
    logic [7:0]           hdr_byte;
    logic [7:0]           out_byte;
`ifdef KEY_FRAME_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    rr_arbiter #(
        .N  (N_SRC),
        .IW (IW)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign hdr_byte   = HDR_BASE | 8'(gidx);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // Pick the granted source's payload and the current byte of the frozen frame.
    always_comb begin
        sel_payload = '0;
        cur_byte    = '0;
        for (int s = 0; s < N_SRC; s++) begin
            if (gidx == IW'(s)) sel_payload = src_data[s*FRAME_W +: FRAME_W];
        end
        for (int b = 0; b < FRAME_BYTES; b++) begin
            if (byte_cnt == CW'(b)) cur_byte = frame_buf[b*8 +: 8];
        end
    end

    // Byte presented to the transmitter depends on which sending state we are in.
    always_comb begin
        out_byte = cur_byte;
        if (state == HDR) out_byte = hdr_byte;
`ifdef KEY_FRAME_CHECKSUM_EN
        else if (state == CSUM) out_byte = csum;
`endif
    end

    // Next-state logic; a byte is issued only from a sending state with the transmitter idle.
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            IDLE: if (enable && arb_valid) state_n = LOAD;
            LOAD: state_n = HDR;
            HDR, SEND: begin
                if (tx_ready) begin
                    issue   = 1'b1;
                    state_n = WAIT;
                end
            end
`ifdef KEY_FRAME_CHECKSUM_EN
            CSUM: begin
                if (tx_ready) begin
                    issue   = 1'b1;
                    state_n = WAIT;
                end
            end
`endif
            WAIT: begin
                if (tx_done) begin
                    case (last_kind)
                        HDR:     state_n = SEND;
                        SEND:    state_n = (byte_cnt == LAST_BYTE) ? AFTER_PAYLOAD : SEND;
                        default: state_n = DONE;
                    endcase
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Payload snapshot taken in LOAD; later src_data changes do not affect the frame.
    always_ff @(posedge clk) begin
        // NOTE: frame_buf is pure data, always written in LOAD before it is read, so it carries no reset.
        if (state == LOAD) frame_buf <= sel_payload;
    end

    // Handshake outputs, grant, round-robin pointer and byte counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_start  <= 1'b0;
            tx_data   <= '0;
            grant     <= '0;
            gidx      <= '0;
            rr_ptr    <= '0;
            byte_cnt  <= '0;
            last_kind <= IDLE;
        end else begin
            tx_start <= issue;
            if (issue) begin
                tx_data   <= out_byte;
                last_kind <= state;
            end
            case (state)
                IDLE: begin
                    if (state_n == LOAD) begin
                        grant <= arb_grant;
                        gidx  <= arb_idx;
                    end
                end
                LOAD: byte_cnt <= '0;
                WAIT: begin
                    if (tx_done) begin
                        if (last_kind == SEND && state_n == SEND) byte_cnt <= byte_cnt + 1'b1;
                        if (state_n == DONE) grant <= '0;
                    end
                end
                DONE: rr_ptr <= (gidx == IW'(N_SRC - 1)) ? '0 : gidx + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef KEY_FRAME_CHECKSUM_EN
    // Running XOR of the header and every payload byte actually issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        csum <= '0;
        else if (state == LOAD)            csum <= hdr_byte;
        else if (issue && state == SEND)   csum <= csum ^ cur_byte;
    end
`endif

endmodule

// File: tb/tb_key_frame_scheduler.sv
// Scoreboard bench for key_frame_scheduler: stimulus pushes expected bytes, frame-end
// markers and grants into queues; a monitor pops and compares as the DUT emits them.
module tb_key_frame_scheduler;
    import key_sched_pkg::*;

    localparam int N         = 5;
    localparam int FB        = 48;
    localparam int TX_CYCLES = 10;

    logic               clk;
    logic               reset;
    logic               enable;
    logic [N-1:0]       req;
    logic [N*FB*8-1:0]  src_data;
    logic               tx_ready;
    logic               tx_done;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic [N-1:0]       grant;
    logic               busy;
    logic               frame_done;

    logic [8:0]   exp_q[$];      // bit 8 set = frame_done marker
    logic [N-1:0] exp_grant[$];
    int n_checks = 0;
    int n_pass = 0;
    int done_count = 0;
    int grant_count = 0;
    int bytes_seen = 0;
    int pending_hold = 0;

    key_frame_scheduler #(
        .N_SRC       (N),
        .FRAME_BYTES (FB),
        .HDR_BASE    (8'hA0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .src_data   (src_data),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .grant      (grant),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    function automatic logic [7:0] pat(input int s, input int b, input int salt);
        return 8'(s * 37 + b + salt * 91);
    endfunction

    task automatic load_src(input int salt);
        for (int s = 0; s < N; s++)
            for (int b = 0; b < FB; b++)
                src_data[(s*FB + b)*8 +: 8] = pat(s, b, salt);
    endtask

    task automatic push_frame(input int s, input int salt);
        logic [7:0] h;
`ifdef KEY_FRAME_CHECKSUM_EN
        logic [7:0] c;
`endif
        h = 8'hA0 | 8'(s);
        exp_grant.push_back(N'(1) << s);
        exp_q.push_back({1'b0, h});
`ifdef KEY_FRAME_CHECKSUM_EN
        c = h;
`endif
        for (int b = 0; b < FB; b++) begin
            exp_q.push_back({1'b0, pat(s, b, salt)});
`ifdef KEY_FRAME_CHECKSUM_EN
            c = c ^ pat(s, b, salt);
`endif
        end
`ifdef KEY_FRAME_CHECKSUM_EN
        exp_q.push_back({1'b0, c});
`endif
        exp_q.push_back(9'h100);
    endtask

    task automatic wait_frames(input int target, input string name);
        int cyc = 0;
        while (done_count < target && cyc < 800 * 5) begin @(posedge clk); #2; cyc++; end
        if (done_count < target) check({name, " frame timeout"}, done_count, target);
    endtask

    task automatic wait_grants(input int target, input string name);
        int cyc = 0;
        while (grant_count < target && cyc < 800 * 5) begin @(posedge clk); #2; cyc++; end
        if (grant_count < target) check({name, " grant timeout"}, grant_count, target);
    endtask

    task automatic wait_bytes(input int target, input string name);
        int cyc = 0;
        while (bytes_seen < target && cyc < 1000) begin @(posedge clk); #2; cyc++; end
        if (bytes_seen < target) check({name, " byte timeout"}, bytes_seen, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_start"}, tx_start, 0);
        check({tag, " tx_data"}, tx_data, 0);
        check({tag, " grant"}, grant, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " frame_done"}, frame_done, 0);
    endtask

    // Transmitter model: accepts a byte when ready, pulses tx_done TX_CYCLES later,
    // optionally stays unready for pending_hold cycles after that done.
    initial begin : tx_model
        int tx_cnt;
        int hold_cnt;
        tx_cnt = 0;
        hold_cnt = 0;
        tx_ready = 1'b1;
        tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_done = 1'b0;
            if (!reset) begin
                tx_cnt = 0;
                hold_cnt = 0;
            end else begin
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        tx_done = 1'b1;
                        hold_cnt = pending_hold;
                        pending_hold = 0;
                    end
                end else if (hold_cnt > 0) begin
                    hold_cnt--;
                end
                if (tx_start) begin
                    check("tx_start only while tx_ready", tx_ready, 1);
                    tx_cnt = TX_CYCLES;
                end
            end
            tx_ready = (tx_cnt == 0) && (hold_cnt == 0);
        end
    end

    // Monitor: pops the scoreboard on every byte, frame end and new grant.
    initial begin : monitor
        logic [N-1:0] prev_grant;
        logic [8:0]   e;
        prev_grant = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                prev_grant = '0;
                bytes_seen = 0;
            end else begin
                if (tx_start) begin
                    if (exp_q.size() == 0) fail_event("tx_start");
                    else begin
                        e = exp_q.pop_front();
                        check("tx byte", {23'd0, 1'b0, tx_data}, {23'd0, e});
                    end
                    bytes_seen++;
                end
                if (frame_done) begin
                    if (exp_q.size() == 0) fail_event("frame_done");
                    else begin
                        e = exp_q.pop_front();
                        check("frame_done position", {23'd0, e}, 32'h100);
                    end
                    done_count++;
                end
                if (grant != '0 && prev_grant == '0) begin
                    if (exp_grant.size() == 0) fail_event("grant");
                    else check("grant", grant, exp_grant.pop_front());
                    grant_count++;
                    bytes_seen = 0;
                end
                prev_grant = grant;
            end
        end
    end

    initial begin : stimulus
        reset = 1'b0;
        enable = 1'b0;
        req = '0;
        load_src(0);
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single source: header A0, payload 0..47, latency grant+1 / tx_start+2.
        push_frame(KEY1, 0);
        @(negedge clk);
        enable = 1'b1;
        req = 5'b00001;
        @(posedge clk); #2;
        check("grant latency", grant, 5'b00001);
        check("busy after grant", busy, 1);
        req = '0;
        @(posedge clk);
        @(posedge clk); #2;
        check("first tx_start latency", tx_start, 1);
        wait_frames(1, "single");

        // Contention from rr_ptr=0: order 0,2,4,0.
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        push_frame(KEY1, 0);
        push_frame(KEY3, 0);
        push_frame(SEED, 0);
        push_frame(KEY1, 0);
        @(negedge clk) req = 5'b10101;
        wait_grants(grant_count + 4, "contention");
        req = '0;
        wait_frames(5, "contention");

        // Snapshot: payload frozen at LOAD, req dropped mid-frame.
        load_src(1);
        push_frame(KEY4, 1);
        @(negedge clk) req = 5'b01000;
        wait_grants(grant_count + 1, "snapshot");
        @(posedge clk); #2;
        load_src(2);
        req = '0;
        wait_frames(6, "snapshot");

        // Backpressure: transmitter unready for 20 cycles mid-frame.
        push_frame(SEED, 2);
        @(negedge clk) req = 5'b10000;
        wait_grants(grant_count + 1, "backpressure");
        req = '0;
        wait_bytes(11, "backpressure");
        pending_hold = 20;
        wait_frames(7, "backpressure");

        // Reset in the middle of payload byte 17, then a fresh frame from source 1.
        load_src(3);
        push_frame(KEY1, 3);
        @(negedge clk) req = 5'b00001;
        wait_grants(grant_count + 1, "reset test");
        req = '0;
        wait_bytes(19, "reset test");
        #4 reset = 1'b0;
        #1;
        check_reset_outputs("mid-frame reset");
        exp_q.delete();
        exp_grant.delete();
        repeat (3) @(negedge clk);
        push_frame(KEY2, 3);
        req = 5'b00010;
        @(negedge clk) reset = 1'b1;
        wait_grants(grant_count + 1, "after reset");
        req = '0;
        wait_frames(8, "after reset");

        // enable dropped mid-frame: frame finishes, no new grant until enable returns.
        push_frame(KEY3, 3);
        @(negedge clk) req = 5'b00100;
        wait_grants(grant_count + 1, "enable");
        enable = 1'b0;
        wait_frames(9, "enable");
        repeat (30) @(posedge clk);
        #2;
        check("no grant while disabled", grant, 0);
        check("idle while disabled", busy, 0);
        push_frame(KEY3, 3);
        enable = 1'b1;
        wait_grants(grant_count + 1, "re-enable");
        req = '0;
        wait_frames(10, "re-enable");

        repeat (5) @(posedge clk);
        #2;
        check("byte scoreboard drained", exp_q.size(), 0);
        check("grant scoreboard drained", exp_grant.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
